// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment brightness scheduler.
package seg7_pkg;

  localparam int unsigned PWM_W       = 8;
  localparam int unsigned PWM_PERIOD  = 256;
  localparam int unsigned DIGIT_IDX_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } state_e;

endpackage

// File: rtl/pwm_slot_counter.sv
// Free-running 8-bit PWM counter with synchronous clear, registered duty compare
// and a period-wrap indication for the dwell counter.
module pwm_slot_counter
  import seg7_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_gate_en,
  input  logic [PWM_W-1:0] i_duty,
  output logic [PWM_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_gate
);

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] w_cnt_d;
  logic             r_gate;

  assign w_cnt_d = i_clear ? '0 : r_cnt + PWM_W'(1);

  // Gate is compared against the count of the cycle it will be visible in.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt  <= '0;
      r_gate <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_gate <= i_gate_en && (i_duty > w_cnt_d);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = (r_cnt == '1);
  assign o_gate = r_gate;

endmodule

// File: rtl/seg7_brightness_scheduler.sv
// Scans NUM_DIGITS digits through one shared PWM with per-digit brightness,
// blanking between digits and double-buffered duty updates at frame boundaries.
module seg7_brightness_scheduler
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned DWELL_PERIODS = 16,
  parameter int unsigned BLANK_CYCLES  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic [DIGIT_IDX_W-1:0] i_cfg_digit,
  input  logic [PWM_W-1:0]       i_cfg_duty,
  output logic                   o_cfg_err,
  output logic [NUM_DIGITS-1:0]  o_digit_en,
  output logic                   o_seg_gate,
  output logic [DIGIT_IDX_W-1:0] o_cur_digit,
  output logic                   o_frame_done
);

  localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned DWELL_W = $clog2(DWELL_PERIODS + 1);

  state_e                 r_state, w_state_d;
  logic [DIGIT_IDX_W-1:0] r_cur, w_cur_d;
  logic [BLANK_W-1:0]     r_blank;
  logic [DWELL_W-1:0]     r_dwell;
  logic [NUM_DIGITS-1:0]  r_digit_en, w_onehot;
  logic                   r_frame_done, r_cfg_ready, r_cfg_err;

  logic [PWM_W-1:0] r_shadow   [NUM_DIGITS];
  logic [PWM_W-1:0] r_active   [NUM_DIGITS];
  logic [PWM_W-1:0] w_shadow_d [NUM_DIGITS];
  logic [PWM_W-1:0] w_cur_duty;

  logic [PWM_W-1:0] w_cnt;
  logic             w_wrap, w_gate;
  logic             w_accept, w_in_range, w_last_digit, w_last_dwell;
  logic             w_blank_end, w_slot_end, w_fd_next, w_stay_drive;

  assign w_accept     = i_cfg_valid && r_cfg_ready;
  assign w_in_range   = 32'(i_cfg_digit) < NUM_DIGITS;
  assign w_last_digit = (r_cur == DIGIT_IDX_W'(NUM_DIGITS - 1));
  assign w_last_dwell = (r_dwell == DWELL_W'(DWELL_PERIODS - 1));
  assign w_blank_end  = (r_blank == BLANK_W'(BLANK_CYCLES - 1));
  assign w_slot_end   = (r_state == StDrive) && w_wrap && w_last_dwell;
  assign w_stay_drive = (r_state == StDrive) && (w_state_d == StDrive);
  // Next cycle is the final DRIVE cycle of the last digit.
  assign w_fd_next    = w_stay_drive && w_last_digit && w_last_dwell &&
                        (w_cnt == PWM_W'(PWM_PERIOD - 2));

  always_comb begin
    w_state_d = r_state;
    w_cur_d   = r_cur;
    if (!i_enable) begin
      w_state_d = StIdle;
      w_cur_d   = '0;
    end else begin
      unique case (r_state)
        StIdle:  w_state_d = StBlank;
        StBlank: if (w_blank_end) w_state_d = StDrive;
        StDrive: begin
          if (w_slot_end) begin
            w_state_d = StBlank;
            w_cur_d   = w_last_digit ? '0 : r_cur + DIGIT_IDX_W'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    w_cur_duty = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_shadow_d[i] = r_shadow[i];
      if (w_accept && (32'(i_cfg_digit) == i)) w_shadow_d[i] = i_cfg_duty;
      w_onehot[i] = (32'(r_cur) == i);
      if (32'(r_cur) == i) w_cur_duty = r_active[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_cur        <= '0;
      r_blank      <= '0;
      r_dwell      <= '0;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cur        <= w_cur_d;
      r_blank      <= ((r_state == StBlank) && (w_state_d == StBlank)) ?
                      r_blank + BLANK_W'(1) : '0;
      r_dwell      <= w_stay_drive ? (w_wrap ? r_dwell + DWELL_W'(1) : r_dwell) : '0;
      r_digit_en   <= (w_state_d == StDrive) ? w_onehot : '0;
      r_frame_done <= w_fd_next;
      r_cfg_ready  <= !w_fd_next;
      r_cfg_err    <= w_accept && !w_in_range;
    end
  end

  // IDLE copies the write-through value so a write in IDLE is never lost.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= w_shadow_d[i];
        if (r_state == StIdle) r_active[i] <= w_shadow_d[i];
        else if (r_frame_done) r_active[i] <= r_shadow[i];
      end
    end
  end

  pwm_slot_counter u_pwm (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (!w_stay_drive),
    .i_gate_en (w_state_d == StDrive),
    .i_duty    (w_cur_duty),
    .o_cnt     (w_cnt),
    .o_wrap    (w_wrap),
    .o_gate    (w_gate)
  );

  assign o_cfg_ready  = r_cfg_ready;
  assign o_cfg_err    = r_cfg_err;
  assign o_digit_en   = r_digit_en;
  assign o_seg_gate   = w_gate;
  assign o_cur_digit  = r_cur;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/seg7_brightness_scheduler.md
# seg7_brightness_scheduler

Time-multiplexes one shared PWM generator across NUM_DIGITS seven-segment digits, giving each digit its own 8-bit brightness. Sits between the switch/config logic and the 7-seg pins: it holds per-digit duty values, sequences the digit enables with a blanking gap between digits, and gates the segment lines with the PWM output. Duty updates are double-buffered and applied only at frame boundaries, so a frame never flickers mid-scan.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, 2..8.
- DWELL_PERIODS, 16: full 256-cycle PWM periods each digit is driven per slot, ≥1.
- BLANK_CYCLES, 8: cycles with all digits off before each digit is driven, ≥1.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; 0 forces IDLE.
- cfg_valid  in  1  duty write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready.
- cfg_digit  in  3  target digit index.
- cfg_duty  in  8  brightness, 0 = off, 255 = 255/256 on.
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_digit ≥ NUM_DIGITS.
- digit_en  out  NUM_DIGITS  one-hot active-high digit enable, or all zero.
- seg_gate  out  1  1 when the segment drivers may light.
- cur_digit  out  3  index of digit currently owning the slot.
- frame_done  out  1  one-cycle pulse at end of last digit's DRIVE.

## Operation
- States: IDLE, BLANK, DRIVE.
- IDLE: digit_en=0, seg_gate=0, cur_digit=0, PWM counter=0. enable sampled 1 → BLANK.
- BLANK: digit_en=0, seg_gate=0, runs exactly BLANK_CYCLES cycles → DRIVE.
- DRIVE: digit_en one-hot at cur_digit; 8-bit counter cnt runs 0..255 and wraps; seg_gate = (active_duty[cur_digit] > cnt), unsigned 8-bit compare. Lasts DWELL_PERIODS×256 cycles, then cur_digit advances (NUM_DIGITS-1 wraps to 0) → BLANK.
- enable sampled 0 in any state → IDLE next cycle; outputs zeroed in that cycle; next start begins at digit 0 with BLANK.
- Double buffer: accepted writes update shadow_duty[cfg_digit]. Shadow copied to active on the frame_done cycle, and every cycle while in IDLE.
- cfg_ready = 0 only during the frame_done cycle (copy cycle); 1 otherwise, including reset release.
- Out-of-range cfg_digit: write accepted, no register changes, cfg_err pulses the next cycle.
- Reset: all outputs 0 except cfg_ready=1; state IDLE; shadow and active duty = 0.

## Timing
- All outputs registered; no combinational path from any input to any output.
- enable high at edge k → BLANK during cycles k+1..k+BLANK_CYCLES; first DRIVE cycle k+BLANK_CYCLES+1 with cnt=0.
- Slot = BLANK_CYCLES + DWELL_PERIODS×256 cycles; frame = NUM_DIGITS × slot (defaults: 4104 / 16416).
- frame_done asserted in the last DRIVE cycle of digit NUM_DIGITS-1; the new active values govern the next BLANK/DRIVE.
- Write accepted at edge k lands in shadow at k+1; visible on seg_gate no earlier than the first DRIVE after the next frame_done (immediately on the next DRIVE if written in IDLE).
- Write presented during the copy cycle is not accepted; the requester holds cfg_valid.
- digit_en never changes directly from one digit to another; at least BLANK_CYCLES all-zero cycles between them.
- Reset asserted mid-DRIVE: digit_en and seg_gate drop asynchronously.

## Structure
- Shared package seg7_pkg: state enum (IDLE, BLANK, DRIVE), PWM_W=8, PWM_PERIOD=256, DIGIT_IDX_W=3.
- One sub-module, pwm_slot_counter: 8-bit counter with synchronous clear, duty compare output, and period-wrap pulse; the scheduler counts wrap pulses against DWELL_PERIODS.

## Test plan
- Reset, enable=0 → all outputs 0, cfg_ready=1; write digit 2 duty 128 in IDLE, then enable → digit 2 DRIVE shows seg_gate high exactly 128 of every 256 cycles.
- Duties {0,1,255,64}, enable → digit 0 never lit, digit 1 lit 1 cycle/period, digit 2 lit 255/256, digit 3 lit 64/256; digit order 0,1,2,3,0; 8-cycle all-zero gap each change.
- Mid-frame write digit 1 duty 200 during digit 0 DRIVE → current frame digit 1 keeps old duty; next frame shows 200.
- cfg_valid held across a frame_done cycle → cfg_ready=0 that cycle, write accepted next cycle only.
- Write cfg_digit=5 with NUM_DIGITS=4 → cfg_err one pulse, no duty changes.
- Drop enable mid-DRIVE of digit 2, raise again → IDLE for ≥1 cycle, restart at digit 0 after 8 blank cycles; async reset mid-DRIVE zeroes digit_en immediately.
